// File: rtl/dsp_pipe_ctrl.sv
// Pipeline control sequencer for a DSP48A1 datapath: per-stage clock enables,
// valid tracking, downstream handshake, and drain/flush-then-scrub sequencing.
module dsp_pipe_ctrl #(
    parameter int STAGES     = 3,
    parameter int CLR_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              drain_req,
    input  logic              flush,
    output logic [STAGES-1:0] ce,
    output logic              dp_rst,
    output logic              drain_done,
    output logic [2:0]        occupancy
);

    typedef enum logic [1:0] {RUN, DRAIN, CLEAR, DONE} state_t;

    state_t            state_reg, state_next;
    logic [STAGES-1:0] v_reg, v_next;
    logic [STAGES-1:0] adv, inc;
    logic [3:0]        clr_cnt_reg, clr_cnt_next;
    logic [2:0]        occ_reg, occ_next;
    logic              dp_rst_reg;

    // Advance ripples from the output stage back toward the input.
    always_comb begin
        adv = '0;
        adv[STAGES-1] = ~v_reg[STAGES-1] | out_ready;
        for (int i = STAGES - 2; i >= 0; i--) begin
            adv[i] = ~v_reg[i] | adv[i+1];
        end
    end

    assign in_ready = rst_n & (state_reg == RUN) & adv[0];

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_inc
            if (gi == 0) begin : g_first
                assign inc[gi] = in_valid & in_ready;
            end else begin : g_rest
                assign inc[gi] = v_reg[gi-1];
            end
        end
    endgenerate

    always_comb begin
        v_next = v_reg;
        if (flush || state_reg == CLEAR) begin
            v_next = '0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                if (adv[i]) v_next[i] = inc[i];
            end
        end
    end

    always_comb begin
        occ_next = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_next = occ_next + 3'(v_next[i]);
        end
    end

    // State register and the registers that move with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= RUN;
            v_reg       <= '0;
            occ_reg     <= '0;
            clr_cnt_reg <= '0;
            dp_rst_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            v_reg       <= v_next;
            occ_reg     <= occ_next;
            clr_cnt_reg <= clr_cnt_next;
            dp_rst_reg  <= (state_next == CLEAR);
        end
    end

    // Next-state logic; flush overrides everything and restarts the scrub.
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        if (flush) begin
            state_next   = CLEAR;
            clr_cnt_next = '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (drain_req) state_next = DRAIN;
                end
                DRAIN: begin
                    if (v_reg == '0) begin
                        state_next   = CLEAR;
                        clr_cnt_next = '0;
                    end
                end
                CLEAR: begin
                    if (clr_cnt_reg == 4'(CLR_CYCLES - 1)) begin
                        state_next = DONE;
                    end else begin
                        clr_cnt_next = clr_cnt_reg + 4'd1;
                    end
                end
                DONE:    state_next = RUN;
                default: state_next = RUN;
            endcase
        end
    end

    // Output logic; a stage never loads a bubble and never loads while scrubbing.
    always_comb begin
        ce         = '0;
        drain_done = 1'b0;
        if (!flush && state_reg != CLEAR) begin
            ce = adv & inc;
        end
        if (state_reg == DONE) begin
            drain_done = 1'b1;
        end
    end

    assign out_valid = v_reg[STAGES-1];
    assign occupancy = occ_reg;
    assign dp_rst    = dp_rst_reg;

endmodule

// File: tb/tb_dsp_pipe_ctrl.sv
// Directed bench for dsp_pipe_ctrl: per-cycle vector table plus hand-written
// asynchronous reset sequences.
module tb_dsp_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic       drain_req, flush, dp_rst, drain_done;
    logic [2:0] ce;
    logic [2:0] occupancy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       iv, orr, dr, fl;
        logic       ir, ov;
        logic [2:0] ce;
        logic       dpr, dd;
        logic [2:0] occ;
    } vec_t;

    vec_t tbl[$];

    dsp_pipe_ctrl #(.STAGES(3), .CLR_CYCLES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .drain_req  (drain_req),
        .flush      (flush),
        .ce         (ce),
        .dp_rst     (dp_rst),
        .drain_done (drain_done),
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, orr, dr, fl, ir, ov, input logic [2:0] c,
                       input logic dpr, dd, input logic [2:0] occ);
        vec_t r;
        r.iv = iv; r.orr = orr; r.dr = dr; r.fl = fl;
        r.ir = ir; r.ov = ov; r.ce = c; r.dpr = dpr; r.dd = dd; r.occ = occ;
        tbl.push_back(r);
    endtask

    task automatic drive(input logic iv, orr, dr, fl);
        in_valid = iv; out_ready = orr; drain_req = dr; flush = fl;
    endtask

    task automatic run_row(input vec_t r, input int idx);
        drive(r.iv, r.orr, r.dr, r.fl);
        @(negedge clk);
        $display("row %0d iv=%b or=%b dr=%b fl=%b -> ir=%b ov=%b ce=%b dp_rst=%b done=%b occ=%0d",
                 idx, r.iv, r.orr, r.dr, r.fl, in_ready, out_valid, ce, dp_rst, drain_done, occupancy);
        chk($sformatf("row%0d.in_ready", idx), 8'(in_ready), 8'(r.ir));
        chk($sformatf("row%0d.out_valid", idx), 8'(out_valid), 8'(r.ov));
        chk($sformatf("row%0d.ce", idx), 8'(ce), 8'(r.ce));
        chk($sformatf("row%0d.dp_rst", idx), 8'(dp_rst), 8'(r.dpr));
        chk($sformatf("row%0d.drain_done", idx), 8'(drain_done), 8'(r.dd));
        chk($sformatf("row%0d.occupancy", idx), 8'(occupancy), 8'(r.occ));
        @(posedge clk);
        #1;
    endtask

    initial begin
        //   iv orr dr fl | ir ov ce      dpr dd occ
        // streaming, 5 operands
        add(1, 1, 0, 0,   1, 0, 3'b001, 0, 0, 0);
        add(1, 1, 0, 0,   1, 0, 3'b011, 0, 0, 1);
        add(1, 1, 0, 0,   1, 0, 3'b111, 0, 0, 2);
        add(1, 1, 0, 0,   1, 1, 3'b111, 0, 0, 3);
        add(1, 1, 0, 0,   1, 1, 3'b111, 0, 0, 3);
        add(0, 1, 0, 0,   1, 1, 3'b110, 0, 0, 3);
        add(0, 1, 0, 0,   1, 1, 3'b100, 0, 0, 2);
        add(0, 1, 0, 0,   1, 1, 3'b000, 0, 0, 1);
        add(0, 1, 0, 0,   1, 0, 3'b000, 0, 0, 0);
        // backpressure: fill, stall 4 cycles, release
        add(1, 0, 0, 0,   1, 0, 3'b001, 0, 0, 0);
        add(1, 0, 0, 0,   1, 0, 3'b011, 0, 0, 1);
        add(1, 0, 0, 0,   1, 0, 3'b111, 0, 0, 2);
        for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 0, 1, 3'b000, 0, 0, 3);
        add(0, 1, 0, 0,   1, 1, 3'b110, 0, 0, 3);
        add(0, 1, 0, 0,   1, 1, 3'b100, 0, 0, 2);
        add(0, 1, 0, 0,   1, 1, 3'b000, 0, 0, 1);
        add(0, 1, 0, 0,   1, 0, 3'b000, 0, 0, 0);
        // bubble compression from v=100 under stall
        add(1, 0, 0, 0,   1, 0, 3'b001, 0, 0, 0);
        add(0, 0, 0, 0,   1, 0, 3'b010, 0, 0, 1);
        add(0, 0, 0, 0,   1, 0, 3'b100, 0, 0, 1);
        add(1, 0, 0, 0,   1, 1, 3'b001, 0, 0, 1);
        add(1, 0, 0, 0,   1, 1, 3'b011, 0, 0, 2);
        add(1, 0, 0, 0,   0, 1, 3'b000, 0, 0, 3);
        add(0, 1, 0, 0,   1, 1, 3'b110, 0, 0, 3);
        add(0, 1, 0, 0,   1, 1, 3'b100, 0, 0, 2);
        add(0, 1, 0, 0,   1, 1, 3'b000, 0, 0, 1);
        // drain with 2 in flight; upstream keeps offering during the sequence
        add(1, 1, 0, 0,   1, 0, 3'b001, 0, 0, 0);
        add(1, 1, 0, 0,   1, 0, 3'b011, 0, 0, 1);
        add(0, 1, 1, 0,   1, 0, 3'b110, 0, 0, 2);
        add(1, 1, 0, 0,   0, 1, 3'b100, 0, 0, 2);
        add(1, 1, 0, 0,   0, 1, 3'b000, 0, 0, 1);
        add(1, 1, 0, 0,   0, 0, 3'b000, 0, 0, 0);
        add(1, 1, 0, 0,   0, 0, 3'b000, 1, 0, 0);
        add(1, 1, 0, 0,   0, 0, 3'b000, 1, 0, 0);
        add(1, 1, 0, 0,   0, 0, 3'b000, 0, 1, 0);
        add(0, 1, 0, 0,   1, 0, 3'b000, 0, 0, 0);
        // flush+drain in DRAIN, then flush again inside CLEAR restarts the count
        add(1, 0, 0, 0,   1, 0, 3'b001, 0, 0, 0);
        add(1, 0, 0, 0,   1, 0, 3'b011, 0, 0, 1);
        add(0, 0, 1, 0,   1, 0, 3'b110, 0, 0, 2);
        add(0, 0, 0, 0,   0, 1, 3'b000, 0, 0, 2);
        add(0, 0, 1, 1,   0, 1, 3'b000, 0, 0, 2);
        add(0, 0, 0, 0,   0, 0, 3'b000, 1, 0, 0);
        add(0, 0, 0, 1,   0, 0, 3'b000, 1, 0, 0);
        add(0, 0, 0, 0,   0, 0, 3'b000, 1, 0, 0);
        add(0, 0, 0, 0,   0, 0, 3'b000, 1, 0, 0);
        add(0, 0, 0, 0,   0, 0, 3'b000, 0, 1, 0);
        add(0, 1, 0, 0,   1, 0, 3'b000, 0, 0, 0);
        // drain on empty pipe; drain_req during CLEAR is ignored
        add(0, 1, 1, 0,   1, 0, 3'b000, 0, 0, 0);
        add(0, 1, 0, 0,   0, 0, 3'b000, 0, 0, 0);
        add(0, 1, 1, 0,   0, 0, 3'b000, 1, 0, 0);
        add(0, 1, 0, 0,   0, 0, 3'b000, 1, 0, 0);
        add(0, 1, 0, 0,   0, 0, 3'b000, 0, 1, 0);
        add(0, 1, 0, 0,   1, 0, 3'b000, 0, 0, 0);

        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        $display("reset: ir=%b ov=%b ce=%b dp_rst=%b done=%b occ=%0d",
                 in_ready, out_valid, ce, dp_rst, drain_done, occupancy);
        chk("rst.in_ready", 8'(in_ready), 8'd0);
        chk("rst.out_valid", 8'(out_valid), 8'd0);
        chk("rst.ce", 8'(ce), 8'd0);
        chk("rst.dp_rst", 8'(dp_rst), 8'd0);
        chk("rst.drain_done", 8'(drain_done), 8'd0);
        chk("rst.occupancy", 8'(occupancy), 8'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) run_row(tbl[i], i + 1);

        // async reset mid-DRAIN with a full pipe
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0); @(posedge clk); #1;
        end
        drive(0, 0, 1, 0); @(posedge clk); #1;
        drive(0, 0, 0, 0);
        #3 rst_n = 1'b0;
        #1;
        $display("reset mid-DRAIN: ir=%b ov=%b occ=%0d", in_ready, out_valid, occupancy);
        chk("rstdrain.out_valid", 8'(out_valid), 8'd0);
        chk("rstdrain.occupancy", 8'(occupancy), 8'd0);
        chk("rstdrain.in_ready", 8'(in_ready), 8'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rstdrain.release_in_ready", 8'(in_ready), 8'd1);

        // async reset mid-CLEAR
        @(posedge clk); #1;
        drive(0, 0, 0, 1); @(posedge clk); #1;
        drive(0, 0, 0, 0);
        @(negedge clk);
        chk("clear.dp_rst_before", 8'(dp_rst), 8'd1);
        #1 rst_n = 1'b0;
        #1;
        $display("reset mid-CLEAR: dp_rst=%b occ=%0d ir=%b", dp_rst, occupancy, in_ready);
        chk("rstclear.dp_rst", 8'(dp_rst), 8'd0);
        chk("rstclear.occupancy", 8'(occupancy), 8'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        $display("after release: ir=%b dp_rst=%b done=%b", in_ready, dp_rst, drain_done);
        chk("rstclear.release_in_ready", 8'(in_ready), 8'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            $display("post-reset cycle %0d: dp_rst=%b done=%b", i, dp_rst, drain_done);
            chk($sformatf("post%0d.drain_done", i), 8'(drain_done), 8'd0);
            chk($sformatf("post%0d.dp_rst", i), 8'(dp_rst), 8'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
